pipe_stage_buf: RTL



---
 rtl/pipe_stage_buf.sv | 91 +++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Purpose: pipeline stage register with a 2-entry skid buffer, flush and a saturating bubble counter.
// Latency: 1 cycle from in_fire to out_valid_o; sustains 1 payload/cycle with out_ready_i high.
// Backpressure: in_ready_o is registered (!s_valid); the skid absorbs the one payload in flight when out_ready_i drops.
module pipe_stage_buf #(
    parameter int DATA_W         = 160,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    input  logic              cnt_clr_i
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Main entry drives the outputs; skid holds the payload that arrived while main was stalled.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CNT_W-1:0]  bubble_cnt;

    logic in_fire;
    logic out_fire;
    logic main_free;

    assign in_ready_o   = !s_valid;
    assign out_valid_o  = m_valid;
    assign out_data_o   = m_data;
    assign bubble_cnt_o = bubble_cnt;

    assign in_fire   = in_valid_i && in_ready_o;
    assign out_fire  = out_valid_o && out_ready_i;
    // Main can take a new payload when empty or when its current one leaves this cycle.
    assign main_free = !m_valid || out_fire;

    // Storage update: flush beats everything, then refill main (skid first), else park input in skid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush_i) begin
            // Any payload accepted this cycle is dropped; a payload taken downstream already left.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            if (CLEAR_ON_FLUSH) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else if (main_free) begin
            if (s_valid) begin
                // in_ready_o is low here, so no input can be accepted alongside the skid move.
                m_data  <= s_data;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                m_data  <= in_data_i;
                m_valid <= 1'b1;
            end else begin
                // Bubble: payload is left as-is, only the valid bit drops.
                m_valid <= 1'b0;
            end
        end else if (in_fire) begin
            s_data  <= in_data_i;
            s_valid <= 1'b1;
        end
    end

    // Bubble counter: clear wins, otherwise count empty-output cycles and stick at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (cnt_clr_i) begin
            bubble_cnt <= '0;
        end else if (!m_valid && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule
